// File: rtl/simple_bfm_pkg.sv
// simple_bfm_pkg: shared types and defaults for the simple req/ack/data protocol.
// Revision: 1.0
`default_nettype none

package simple_bfm_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } rsp_state_e;

endpackage

`default_nettype wire

// File: rtl/simple_rsp_fifo.sv
// simple_rsp_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// Revision: 1.0
`default_nettype none

module simple_rsp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/simple_rsp_bfm.sv
// simple_rsp_bfm: responder end of the req/ack/data protocol with latency, capture FIFO and error flag.
// Revision: 1.0
`default_nettype none

module simple_rsp_bfm
  import simple_bfm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int WAIT_W = DEF_WAIT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic [DATA_W-1:0]        data,
  output logic                     ack,
  input  logic [WAIT_W-1:0]        wait_cycles,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [31:0]              xfer_count,
  output logic                     proto_err
);

  rsp_state_e        state;
  rsp_state_e        state_nxt;
  logic [WAIT_W-1:0] wcnt;
  logic [WAIT_W-1:0] wcnt_nxt;
  logic              push;
  logic              err_set;
  logic              fifo_full;
  logic              fifo_empty;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    push      = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        // Full check happens only here; nothing else can push before ACK.
        if (req && !fifo_full) begin
          if (wait_cycles == '0) begin
            state_nxt = ACK;
          end else begin
            state_nxt = WAIT;
            wcnt_nxt  = wait_cycles;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (wcnt == WAIT_W'(1)) begin
          state_nxt = ACK;
        end else begin
          wcnt_nxt = wcnt - 1'b1;
        end
      end
      ACK: begin
        state_nxt = IDLE;
        push      = req;
        err_set   = !req;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      xfer_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (push) begin
        xfer_count <= xfer_count + 32'd1;
      end
      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign ack      = (state == ACK);
  assign rd_valid = !fifo_empty;

  simple_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (data),
    .pop   (rd_ready),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

`default_nettype wire
